// File: rtl/reg_readback_serializer.sv
// Snapshot-and-stream readback: captures a wide register word on request and
// emits it MSB-first as narrow valid/ready beats, one frame per accepted request.
module reg_readback_serializer #(
  parameter int               width      = 16,
  parameter int               beat_width = 4,
  parameter logic [width-1:0] init       = {width{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [width-1:0]      I,
  input  logic                  req,
  output logic [beat_width-1:0] O,
  output logic                  O_valid,
  input  logic                  O_ready,
  output logic                  O_last,
  output logic                  busy
);

  localparam int             N    = width / beat_width;
  localparam int             CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                r_state, w_state_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [width-1:0]      r_snap, w_snap_next;
  logic [beat_width-1:0] r_o, w_o_next;
  logic                  r_valid, w_valid_next;
  logic                  r_last, w_last_next;
  logic                  w_xfer;
  logic [beat_width-1:0] w_beats [N];

  assign w_xfer = r_valid & O_ready;

  // Beat slices of the next snapshot, so each output beat can be registered.
  for (genvar gi = 0; gi < N; gi++) begin : g_beats
    assign w_beats[gi] = w_snap_next[width-1-gi*beat_width -: beat_width];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_snap  <= init;
      r_o     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_snap  <= w_snap_next;
      r_o     <= w_o_next;
      r_valid <= w_valid_next;
      r_last  <= w_last_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_snap_next  = r_snap;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_next = S_SEND;
          w_snap_next  = I;
          w_cnt_next   = '0;
        end
      end
      S_SEND: begin
        if (w_xfer) begin
          if (r_cnt != LAST) begin
            w_cnt_next = r_cnt + 1'b1;
          end else if (req) begin
            // Final beat accepted while a new request waits: chain with no gap.
            w_snap_next = I;
            w_cnt_next  = '0;
          end else begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    w_valid_next = (w_state_next == S_SEND);
    w_last_next  = w_valid_next && (w_cnt_next == LAST);
    w_o_next     = w_valid_next ? w_beats[w_cnt_next] : '0;
  end

  assign O       = r_o;
  assign O_valid = r_valid;
  assign O_last  = r_last;
  assign busy    = r_valid;

endmodule

// File: tb/tb_reg_readback_serializer.sv
// Bench for reg_readback_serializer: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a beat-queue model.
module tb_reg_readback_serializer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [15:0] I = 16'h0000;
  logic        req = 1'b0;
  logic [3:0]  O;
  logic        O_valid;
  logic        O_ready = 1'b0;
  logic        O_last;
  logic        busy;

  reg_readback_serializer #(.width(16), .beat_width(4), .init(16'h0000)) dut (
    .CLK(CLK), .RESET(RESET), .I(I), .req(req), .O(O), .O_valid(O_valid),
    .O_ready(O_ready), .O_last(O_last), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a frame is just a list of pending beats; the head is what's on the bus.
  typedef struct { logic [3:0] d; logic l; } beat_t;
  beat_t q[$];

  typedef struct {
    logic rst; logic rq; logic rdy; logic [15:0] din;
    logic ev; logic [3:0] eo; logic el;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    beat_t b;
    if (RESET) begin
      q.delete();
    end else begin
      if (q.size() > 0 && O_ready) void'(q.pop_front());
      if (req && q.size() == 0) begin
        for (int k = 0; k < 4; k++) begin
          b.d = 4'((I >> (12 - 4*k)) & 16'h000F);
          b.l = (k == 3);
          q.push_back(b);
        end
      end
    end
  endtask

  task automatic model_check();
    logic       ev;
    logic [3:0] eo;
    logic       el;
    ev = (q.size() > 0);
    eo = ev ? q[0].d : 4'h0;
    el = ev ? q[0].l : 1'b0;
    chk("model_valid", {15'd0, O_valid}, {15'd0, ev});
    chk("model_data",  {12'd0, O},       {12'd0, eo});
    chk("model_last",  {15'd0, O_last},  {15'd0, el});
    chk("model_busy",  {15'd0, busy},    {15'd0, ev});
  endtask

  task automatic step(input logic rst, input logic rq, input logic rdy, input logic [15:0] din);
    RESET = rst; req = rq; O_ready = rdy; I = din;
    if (!rst && O_valid && O_ready)
      $display("beat %h last %0d", O, O_last);
    model_update();
    @(posedge CLK);
    #1;
    model_check();
  endtask

  task automatic expect_out(input string nm, input logic ev, input logic [3:0] eo, input logic el);
    chk({nm, "_valid"}, {15'd0, O_valid}, {15'd0, ev});
    chk({nm, "_data"},  {12'd0, O},       {12'd0, eo});
    chk({nm, "_last"},  {15'd0, O_last},  {15'd0, el});
  endtask

  function automatic vec_t mk(input logic rq, input logic [15:0] din,
                              input logic ev, input logic [3:0] eo, input logic el);
    vec_t v;
    v.rst = 1'b0; v.rq = rq; v.rdy = 1'b1; v.din = din;
    v.ev = ev; v.eo = eo; v.el = el;
    return v;
  endfunction

  initial begin
    // Single frame A5C3
    tbl[0]  = mk(1, 16'hA5C3, 1, 4'hA, 0);
    tbl[1]  = mk(0, 16'h0000, 1, 4'h5, 0);
    tbl[2]  = mk(0, 16'h0000, 1, 4'hC, 0);
    tbl[3]  = mk(0, 16'h0000, 1, 4'h3, 1);
    tbl[4]  = mk(0, 16'h0000, 0, 4'h0, 0);
    // Back-to-back 00FF then BEEF
    tbl[5]  = mk(1, 16'h00FF, 1, 4'h0, 0);
    tbl[6]  = mk(0, 16'h0000, 1, 4'h0, 0);
    tbl[7]  = mk(0, 16'h0000, 1, 4'hF, 0);
    tbl[8]  = mk(0, 16'h0000, 1, 4'hF, 1);
    tbl[9]  = mk(1, 16'hBEEF, 1, 4'hB, 0);
    tbl[10] = mk(0, 16'h0000, 1, 4'hE, 0);
    tbl[11] = mk(0, 16'h0000, 1, 4'hE, 0);
    tbl[12] = mk(0, 16'h0000, 1, 4'hF, 1);
    tbl[13] = mk(0, 16'h0000, 0, 4'h0, 0);
    // Requests during a frame are dropped
    tbl[14] = mk(1, 16'h7E81, 1, 4'h7, 0);
    tbl[15] = mk(1, 16'hFFFF, 1, 4'hE, 0);
    tbl[16] = mk(1, 16'hFFFF, 1, 4'h8, 0);
    tbl[17] = mk(1, 16'hFFFF, 1, 4'h1, 1);
    tbl[18] = mk(0, 16'h0000, 0, 4'h0, 0);

    // Reset held with req and I active
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 16'hFFFF);
      expect_out("reset", 0, 4'h0, 0);
      chk("reset_busy", {15'd0, busy}, 16'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 1, 16'hFFFF);
      expect_out("post_reset", 0, 4'h0, 0);
    end

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].rq, tbl[i].rdy, tbl[i].din);
      expect_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].eo, tbl[i].el);
    end

    // Backpressure with I changing after acceptance
    step(0, 1, 0, 16'h1234); expect_out("bp1", 1, 4'h1, 0);
    step(0, 0, 0, 16'hFFFF); expect_out("bp2", 1, 4'h1, 0);
    step(0, 0, 0, 16'hFFFF); expect_out("bp3", 1, 4'h1, 0);
    step(0, 0, 0, 16'hFFFF); expect_out("bp4", 1, 4'h1, 0);
    step(0, 0, 1, 16'hFFFF); expect_out("bp5", 1, 4'h2, 0);
    step(0, 0, 1, 16'hFFFF); expect_out("bp6", 1, 4'h3, 0);
    step(0, 0, 1, 16'hFFFF); expect_out("bp7", 1, 4'h4, 1);
    step(0, 0, 1, 16'hFFFF); expect_out("bp8", 0, 4'h0, 0);

    // Reset mid-frame, then a clean frame
    step(0, 1, 1, 16'h1234); expect_out("rm1", 1, 4'h1, 0);
    step(0, 0, 1, 16'h0000); expect_out("rm2", 1, 4'h2, 0);
    step(1, 0, 1, 16'h0000); expect_out("rm3", 0, 4'h0, 0);
    step(0, 0, 1, 16'h0000); expect_out("rm4", 0, 4'h0, 0);
    step(0, 1, 1, 16'h5A5A); expect_out("rm5", 1, 4'h5, 0);
    step(0, 0, 1, 16'h0000); expect_out("rm6", 1, 4'hA, 0);
    step(0, 0, 1, 16'h0000); expect_out("rm7", 1, 4'h5, 0);
    step(0, 0, 1, 16'h0000); expect_out("rm8", 1, 4'hA, 1);
    step(0, 0, 1, 16'h0000); expect_out("rm9", 0, 4'h0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) < 7), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
